// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and constants for the data-memory arbiter.
//   state_t      : arbiter FSM states (IDLE, ACCESS, RESP)
//   DEF_ADDR_W   : default byte-address width of the shared memory
//   WORD_BYTES   : bytes per memory word
//   addr_bad()   : true when an address is misaligned or outside the memory
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int DEF_ADDR_W = 6;
  localparam int WORD_BYTES = 4;

  // An access is rejected when it does not hit a whole word inside the
  // 2^aw-byte memory.
  function automatic logic addr_bad(input logic [31:0] addr, input int aw);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr & 32'(WORD_BYTES - 1)) != 32'd0;
    out_of_range = (addr >> aw) != 32'd0;
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-requester round-robin winner selection.
//   clk, rst : clock and synchronous active-high reset
//   req      : request vector, bit i = requester i
//   take     : the current winner is being accepted this cycle
//   win      : index of the winning requester (valid when any_req)
//   any_req  : at least one requester is asking
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       win,
  output logic       any_req
);

  // Preferred requester; after every accepted grant it points at the other one.
  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take) begin
      ptr <= ~win;
    end
  end

  // A lone requester always wins; a tie goes to the preferred one.
  always_comb begin
    any_req = |req;
    if (req[0] && req[1]) begin
      win = ptr;
    end else begin
      win = req[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- arbitrates a CPU (requester 0) and a DMA/debug port
// (requester 1) onto one single-ported data memory.
//   clk, rst              : clock and synchronous active-high reset
//   rN_req/we/addr/wdata  : requester N access request and qualifiers
//   rN_gnt                : one-cycle pulse, request accepted
//   rN_done/err/rdata     : one-cycle completion pulse, reject flag, read data
//   mem_en/we/addr/wdata  : memory access strobe and command
//   mem_rdata             : memory read data, valid the cycle after a read
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREQ   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [31:0]       r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [31:0]       r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t state;
  state_t state_nxt;

  logic [NREQ-1:0] req_vec;
  logic            win_id;
  logic            any_req;
  logic            arb_take;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  logic              lat_we;
  logic              lat_id;
  logic              lat_bad;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  assign req_vec = {r1_req, r0_req};

  // Arbitration happens whenever the memory slot is free: IDLE, or the
  // response cycle of the previous access.
  assign arb_take = any_req && ((state == IDLE) || (state == RESP));

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_vec),
    .take    (arb_take),
    .win     (win_id),
    .any_req (any_req)
  );

  always_comb begin
    if (win_id) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end else begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = any_req ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The reject decision is made once at acceptance so ACCESS/RESP only
  // look at a single flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
      lat_bad   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (arb_take) begin
      lat_we    <= sel_we;
      lat_id    <= win_id;
      lat_bad   <= addr_bad(sel_addr, ADDR_W);
      lat_addr  <= sel_addr[ADDR_W-1:0];
      lat_wdata <= sel_wdata;
    end
  end

  // Outputs are forced quiet during reset, which also discards a done
  // pulse for an access caught in flight.
  always_comb begin
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    r0_done   = 1'b0;
    r1_done   = 1'b0;
    r0_err    = 1'b0;
    r1_err    = 1'b0;
    r0_rdata  = '0;
    r1_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        ACCESS: begin
          r0_gnt = ~lat_id;
          r1_gnt = lat_id;
          if (!lat_bad) begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
          end
        end
        RESP: begin
          r0_done = ~lat_id;
          r1_done = lat_id;
          r0_err  = ~lat_id & lat_bad;
          r1_err  = lat_id & lat_bad;
          if (!lat_bad && !lat_we) begin
            if (lat_id) begin
              r1_rdata = mem_rdata;
            end else begin
              r0_rdata = mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- self-checking bench for dmem_arbiter. Two requester
// queues drive the ports, a behavioural memory answers the mem_* port, and
// a transaction-level model predicts every output on every cycle.
module tb_dmem_arbiter;

  localparam int ADDR_W = 6;
  localparam int NWORDS = (1 << ADDR_W) / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_req, r0_we, r0_gnt, r0_done, r0_err;
  logic [31:0]       r0_addr, r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_gnt, r1_done, r1_err;
  logic [31:0]       r1_addr, r1_wdata, r1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        v;
    logic        id;
    txn_t        t;
    logic        bad;
    logic [31:0] rd;
  } acc_t;

  txn_t        q0[$];
  txn_t        q1[$];
  logic [31:0] bmem   [NWORDS];
  logic [31:0] refMem [NWORDS];
  bit          memInit = 1'b0;
  acc_t        gslot, dslot;
  bit          ptr;
  int          nChecks, nErrors, cycle, gcnt0, gcnt1;

  function automatic logic [31:0] initVal(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  // Behavioural single-port memory; read data is garbage except after a read.
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < NWORDS; i++) bmem[i] <= initVal(i);
      memInit <= 1'b1;
    end else if (mem_en && mem_we) begin
      bmem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= bmem[mem_addr[ADDR_W-1:2]];
    else                   mem_rdata <= $urandom;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  task automatic pushTxn(input int who, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (who == 0) q0.push_back(t);
    else          q1.push_back(t);
  endtask

  // One clock cycle: drive the queue heads, then predict and check outputs.
  task automatic applyStimulus(input bit rstIn);
    acc_t        curG, curD;
    logic        eEn;
    logic [31:0] eRd0, eRd1;
    bit          w;
    @(posedge clk);
    #1;
    cycle++;
    rst    = rstIn;
    r0_req = (q0.size() > 0);
    r0_we  = r0_req ? q0[0].we    : 1'b0;
    r0_addr  = r0_req ? q0[0].addr  : 32'd0;
    r0_wdata = r0_req ? q0[0].wdata : 32'd0;
    r1_req = (q1.size() > 0);
    r1_we  = r1_req ? q1[0].we    : 1'b0;
    r1_addr  = r1_req ? q1[0].addr  : 32'd0;
    r1_wdata = r1_req ? q1[0].wdata : 32'd0;
    #1;
    if (rstIn) begin
      gslot = '0; dslot = '0; ptr = 1'b0; curG = '0; curD = '0;
    end else begin
      curG = gslot; curD = dslot;
    end
    if (curG.v && !curG.bad) begin
      if (curG.t.we) refMem[curG.t.addr[ADDR_W-1:2]] = curG.t.wdata;
      else           curG.rd = refMem[curG.t.addr[ADDR_W-1:2]];
    end
    eEn  = curG.v && !curG.bad;
    eRd0 = (curD.v && !curD.id && !curD.t.we && !curD.bad) ? curD.rd : 32'd0;
    eRd1 = (curD.v &&  curD.id && !curD.t.we && !curD.bad) ? curD.rd : 32'd0;
    checkOutput("r0_gnt",  32'(r0_gnt),  32'(curG.v && !curG.id));
    checkOutput("r1_gnt",  32'(r1_gnt),  32'(curG.v &&  curG.id));
    checkOutput("r0_done", 32'(r0_done), 32'(curD.v && !curD.id));
    checkOutput("r1_done", 32'(r1_done), 32'(curD.v &&  curD.id));
    checkOutput("r0_err",  32'(r0_err),  32'(curD.v && !curD.id && curD.bad));
    checkOutput("r1_err",  32'(r1_err),  32'(curD.v &&  curD.id && curD.bad));
    checkOutput("r0_rdata", r0_rdata, eRd0);
    checkOutput("r1_rdata", r1_rdata, eRd1);
    checkOutput("mem_en",   32'(mem_en),   32'(eEn));
    checkOutput("mem_we",   32'(mem_we),   32'(eEn && curG.t.we));
    checkOutput("mem_addr", 32'(mem_addr), eEn ? curG.t.addr : 32'd0);
    checkOutput("mem_wdata", mem_wdata,    eEn ? curG.t.wdata : 32'd0);
    gcnt0 += int'(r0_gnt);
    gcnt1 += int'(r1_gnt);
    if (!rstIn) begin
      if (!curG.v && (q0.size() > 0 || q1.size() > 0)) begin
        if (q0.size() > 0 && q1.size() > 0) w = ptr;
        else                                w = (q1.size() > 0);
        ptr = !w;
        gslot    = '0;
        gslot.v  = 1'b1;
        gslot.id = w;
        gslot.t  = w ? q1[0] : q0[0];
        gslot.bad = (gslot.t.addr % 4 != 0) || (gslot.t.addr >= (1 << ADDR_W));
      end else begin
        gslot = '0;
      end
      if (curG.v) begin
        if (curG.id) void'(q1.pop_front());
        else         void'(q0.pop_front());
      end
      dslot = curG;
    end
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, 63)) | 32'd1;
      1:       return (32'd64 << $urandom_range(0, 25)) + 32'(4 * $urandom_range(0, 15));
      default: return 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    nChecks = 0; nErrors = 0; cycle = 0; gcnt0 = 0; gcnt1 = 0;
    gslot = '0; dslot = '0; ptr = 1'b0;
    rst = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    for (int i = 0; i < NWORDS; i++) refMem[i] = initVal(i);

    repeat (3) applyStimulus(1'b1);
    applyStimulus(1'b0);

    $display("[TB] CPU write then read of 0x08");
    pushTxn(0, 1'b1, 32'h08, 32'hDEADBEEF);
    pushTxn(0, 1'b0, 32'h08, 32'd0);
    repeat (6) applyStimulus(1'b0);

    $display("[TB] both requesters streaming from reset");
    repeat (2) applyStimulus(1'b1);
    gcnt0 = 0; gcnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      pushTxn(0, 1'b0, 32'(4 * i), 32'd0);
      pushTxn(1, 1'b0, 32'h20 + 32'(4 * i), 32'd0);
    end
    repeat (20) applyStimulus(1'b0);
    checkOutput("gnt0_cnt", 32'(gcnt0), 32'd4);
    checkOutput("gnt1_cnt", 32'(gcnt1), 32'd4);

    $display("[TB] rejected accesses on r1");
    pushTxn(1, 1'b0, 32'h06, 32'd0);
    pushTxn(1, 1'b0, 32'h40, 32'd0);
    repeat (6) applyStimulus(1'b0);

    $display("[TB] reset during response of an r0 read");
    pushTxn(0, 1'b0, 32'h08, 32'd0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    pushTxn(0, 1'b0, 32'h0C, 32'd0);
    pushTxn(1, 1'b0, 32'h10, 32'd0);
    repeat (8) applyStimulus(1'b0);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0)
        pushTxn(0, 1'($urandom_range(0, 1)), randAddr(), $urandom);
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        pushTxn(1, 1'($urandom_range(0, 1)), randAddr(), $urandom);
      applyStimulus($urandom_range(0, 79) == 0);
    end
    repeat (20) applyStimulus(1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, byte-address width of the shared data memory (2^ADDR_W bytes).
REQ-002 Parameter NREQ, fixed 2, number of requesters (0 = CPU load/store, 1 = DMA/debug).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset rst, synchronous, active-high.
REQ-005 rN_req  in  1  requester N access request, N = 0..1; held with its qualifiers until rN_gnt.
REQ-006 rN_we  in  1  requester N write (1) / read (0).
REQ-007 rN_addr  in  32  requester N byte address, word-aligned.
REQ-008 rN_wdata  in  32  requester N write data, little-endian (bits 7:0 at addr).
REQ-009 rN_gnt  out  1  one-cycle pulse; requester N's request was accepted.
REQ-010 rN_done  out  1  one-cycle pulse; requester N's access is complete.
REQ-011 rN_rdata  out  32  read data, valid while rN_done is high for a read; 0 otherwise.
REQ-012 rN_err  out  1  pulses with rN_done when the access was rejected.
REQ-013 mem_en  out  1  memory access strobe.
REQ-014 mem_we  out  1  memory write enable; qualified by mem_en.
REQ-015 mem_addr  out  ADDR_W  word-aligned byte address to the memory.
REQ-016 mem_wdata  out  32  write data to the memory.
REQ-017 mem_rdata  in  32  memory read data; valid on the cycle after mem_en with mem_we=0.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 IDLE: if any req is high, select a winner, latch its we/addr/wdata and id, and go to ACCESS; otherwise stay in IDLE.
REQ-020 ACCESS: pulse the winner's gnt for exactly one cycle and drive mem_* from the latched request; go to RESP.
REQ-021 RESP: pulse the winner's done for one cycle, with rdata = mem_rdata for reads and 0 for writes.
REQ-022 From RESP, go to ACCESS if any req is pending, re-arbitrating in that cycle; otherwise go to IDLE.
REQ-023 Latency: req sampled in cycle N gives gnt in N+1 and done in N+2; the peak rate is one access per 2 cycles.
REQ-024 Arbitration is two-way round-robin; a one-bit pointer names the preferred requester.
REQ-025 When both requesters request in the same arbitration cycle, the preferred requester wins; the loser keeps req high and wins at the next arbitration.
REQ-026 After any grant to requester i, the pointer moves to the other requester.
REQ-027 If only one requester is active, it is served regardless of the pointer.
REQ-028 An access is rejected if addr[1:0] != 0 or addr >= 2^ADDR_W.
REQ-029 For a rejected access, mem_en stays 0 in ACCESS, gnt still pulses, and in RESP done and err pulse together with rdata = 0.
REQ-030 mem_en is high only in ACCESS.
REQ-031 mem_addr = latched addr[ADDR_W-1:0].
REQ-032 In cycles where mem_en is 0, mem_we, mem_addr and mem_wdata are 0.
REQ-033 A requester deasserting req before gnt is a protocol violation; the behaviour is undefined and the bench treats it as an error.

Reset
REQ-034 When rst is high at a clock edge: state = IDLE, pointer = 0 (CPU preferred), latched request cleared.
REQ-035 While in reset, all gnt/done/err/rdata/mem_* outputs are 0.
REQ-036 A transaction in ACCESS or RESP when rst asserts is discarded: no done pulse, and a write already issued is not retracted.

Structure
REQ-037 Package dmem_pkg holds the state enum {IDLE, ACCESS, RESP}, the default ADDR_W and the WORD_BYTES = 4 constant.
REQ-038 One sub-module, rr_arb2, contains the round-robin pointer and the two-requester winner logic.
REQ-039 The memory itself is outside this block.

Verification
REQ-040 CPU write 0xDEADBEEF to 0x08, then CPU read 0x08 -> gnt at N+1, done at N+2, r0_rdata = 0xDEADBEEF, mem_wdata = 0xDEADBEEF on the write.
REQ-041 r0 and r1 both request reads from reset -> r0 granted first, r1 granted at the next arbitration (one cycle after r0_done), no cycle without the pointer alternating.
REQ-042 Both requesters hold req continuously for 8 accesses -> grants alternate 0,1,0,1,...; each requester receives exactly 4 grants.
REQ-043 r1 reads 0x06 (misaligned) and then 0x40 with ADDR_W=6 -> mem_en never rises, r1_err and r1_done pulse together, r1_rdata = 0.
REQ-044 rst asserted during RESP of an r0 read -> no r0_done, all outputs 0 next cycle, and the next simultaneous request grants r0.
